// File: rtl/if_fetch_if.sv
// Bundles the fetch stage's memory-bus and IF_ID-side signals; master = fetch stage,
// slave = memory arbiter plus downstream pipeline register.
interface if_fetch_if;
  logic        memGnt_in;
  logic [7:0]  memData_in;
  logic        memRE_out;
  logic [31:0] memAddr_out;
  logic        stall_in;
  logic        jumpE_in;
  logic [31:0] jumpAddr_in;
  logic        instValid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;

  modport master (
    input  memGnt_in, memData_in, stall_in, jumpE_in, jumpAddr_in,
    output memRE_out, memAddr_out, instValid_out, pc_out, inst_out
  );

  modport slave (
    output memGnt_in, memData_in, stall_in, jumpE_in, jumpAddr_in,
    input  memRE_out, memAddr_out, instValid_out, pc_out, inst_out
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian word from a byte-wide bus, one byte per cycle.
// Optional direct-mapped I-cache is enabled by defining IF_ICACHE_EN.
//
// Handshake: the held word {pc_out, inst_out} is consumed on a rising edge where
// instValid_out=1 and stall_in=0; a redirect (jumpE_in) overrides everything and also
// retires any held word. A memory byte is returned one cycle after its address is driven.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  if_fetch_if.master bus,
  output logic [2:0] state_dbg_o
);
  typedef enum logic [2:0] {
    F0   = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    F3   = 3'd3,
    F4   = 3'd4,
    HOLD = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [23:0] buf_q, buf_d;
  logic        re_q, re_d;
  logic [31:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] inst_q, inst_d;
  logic        start;
  logic        hit_cur, hit_next;
  logic [31:0] hit_data;
  logic [31:0] fetched_word;

  assign fetched_word = {bus.memData_in, buf_q};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= F0;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      re_q     <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      inst_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      re_q     <= re_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
    end
  end

  // F0 with re_q=0 is the idle/restart point: the request is (re)issued once the grant is back.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    start   = 1'b0;
    if (bus.jumpE_in) begin
      state_d = F0;
      pc_d    = {bus.jumpAddr_in[31:2], 2'b00};
      start   = 1'b1;
    end else begin
      unique case (state_q)
        F0: begin
          if (hit_cur) begin
            state_d = HOLD;
          end else if (bus.memGnt_in) begin
            if (re_q) state_d = F1;
            else      start   = 1'b1;
          end
        end
        F1:   state_d = bus.memGnt_in ? F2   : F0;
        F2:   state_d = bus.memGnt_in ? F3   : F0;
        F3:   state_d = bus.memGnt_in ? F4   : F0;
        F4:   state_d = bus.memGnt_in ? HOLD : F0;
        HOLD: begin
          if (!bus.stall_in) begin
            state_d = F0;
            pc_d    = pc_q + 32'd4;
            start   = 1'b1;
          end
        end
        default: state_d = F0;
      endcase
    end
  end

  always_comb begin
    re_d     = 1'b0;
    addr_d   = addr_q;
    buf_d    = buf_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    if (start) begin
      re_d    = !hit_next;
      addr_d  = pc_d;
      valid_d = 1'b0;
    end else if (state_d == F1 || state_d == F2 || state_d == F3) begin
      re_d   = 1'b1;
      addr_d = pc_q + {29'd0, state_d};
    end
    if (state_q == F1 && state_d == F2) buf_d[7:0]   = bus.memData_in;
    if (state_q == F2 && state_d == F3) buf_d[15:8]  = bus.memData_in;
    if (state_q == F3 && state_d == F4) buf_d[23:16] = bus.memData_in;
    if (state_q == F4 && state_d == HOLD) begin
      valid_d  = 1'b1;
      pc_out_d = pc_q;
      inst_d   = fetched_word;
    end
    if (state_q == F0 && state_d == HOLD) begin
      valid_d  = 1'b1;
      pc_out_d = pc_q;
      inst_d   = hit_data;
    end
  end

`ifdef IF_ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] line_v_q;
  logic [TAG_W-1:0]        line_tag_q  [ICACHE_LINES];
  logic [31:0]             line_word_q [ICACHE_LINES];
  logic [IDX_W-1:0]        idx_cur, idx_next;
  logic                    fill;

  assign idx_cur  = pc_q[IDX_W+1:2];
  assign idx_next = pc_d[IDX_W+1:2];
  assign hit_cur  = line_v_q[idx_cur]  && (line_tag_q[idx_cur]  == pc_q[31:IDX_W+2]);
  assign hit_next = line_v_q[idx_next] && (line_tag_q[idx_next] == pc_d[31:IDX_W+2]);
  assign hit_data = line_word_q[idx_cur];
  // Only a completed memory fetch fills; aborted words never reach F4 -> HOLD.
  assign fill     = (state_q == F4) && (state_d == HOLD);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)   line_v_q          <= '0;
    else if (fill) line_v_q[idx_cur] <= 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (fill) begin
      line_tag_q[idx_cur]  <= pc_q[31:IDX_W+2];
      line_word_q[idx_cur] <= fetched_word;
    end
  end
`else
  assign hit_cur  = 1'b0;
  assign hit_next = 1'b0;
  assign hit_data = 32'h0;
`endif

  assign bus.memRE_out     = re_q;
  assign bus.memAddr_out   = addr_q;
  assign bus.instValid_out = valid_q;
  assign bus.pc_out        = pc_out_q;
  assign bus.inst_out      = inst_q;
  assign state_dbg_o       = state_q;
endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios plus a randomized run against a PC-sequence model.
module tb_if_fetch;
  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [2:0] state_dbg;
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mem [1024];

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0), .ICACHE_LINES(64)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  always #5 clk_in = ~clk_in;

  // Memory returns the addressed byte one cycle later only if requested and granted; else garbage.
  always @(posedge clk_in)
    bus.memData_in <= (bus.memRE_out && bus.memGnt_in) ? mem[bus.memAddr_out[9:0]] : 8'($urandom);

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] a1, a2, a3;
    a1 = a + 32'd1;
    a2 = a + 32'd2;
    a3 = a + 32'd3;
    return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
  endfunction

  task automatic jump_to(input logic [31:0] a);
    bus.jumpE_in    = 1'b1;
    bus.jumpAddr_in = a;
    @(negedge clk_in);
    bus.jumpE_in    = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    for (int i = 0; i < max_cycles && !bus.instValid_out; i++) @(negedge clk_in);
    ok = bus.instValid_out;
  endtask

  task automatic test_reset;
    rst_in = 1'b0;
    bus.memGnt_in = 1'b1; bus.stall_in = 1'b0; bus.jumpE_in = 1'b0; bus.jumpAddr_in = '0;
    repeat (3) @(negedge clk_in);
    n_vec++; if (bus.instValid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.instValid_out); end
    n_vec++; if (bus.pc_out !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", bus.pc_out); end
    n_vec++; if (bus.inst_out !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", bus.inst_out); end
    n_vec++; if (bus.memRE_out !== 1'b0) begin n_err++; $display("FAIL reset_re got %b want 0", bus.memRE_out); end
    n_vec++; if (bus.memAddr_out !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.memAddr_out); end
  endtask

  task automatic test_first_fetch;
    rst_in = 1'b1;
    for (int i = 0; i < 10 && !bus.memRE_out; i++) @(negedge clk_in);
    n_vec++; if (bus.memRE_out !== 1'b1 || bus.memAddr_out !== 32'h0) begin
      n_err++; $display("FAIL first_addr0 got re=%b addr=%h want re=1 addr=0", bus.memRE_out, bus.memAddr_out); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_in);
      if (k <= 3) begin
        n_vec++; if (bus.memRE_out !== 1'b1 || bus.memAddr_out !== 32'(k)) begin
          n_err++; $display("FAIL first_addr%0d got re=%b addr=%h want re=1 addr=%0d", k, bus.memRE_out, bus.memAddr_out, k); end
      end
      if (k < 5) begin
        n_vec++; if (bus.instValid_out !== 1'b0) begin n_err++; $display("FAIL first_early_valid cycle %0d got 1 want 0", k); end
      end else begin
        n_vec++; if (bus.instValid_out !== 1'b1) begin n_err++; $display("FAIL first_latency got valid=%b want 1", bus.instValid_out); end
        n_vec++; if (bus.pc_out !== 32'h0) begin n_err++; $display("FAIL first_pc got %h want 0", bus.pc_out); end
        n_vec++; if (bus.inst_out !== 32'h00100513) begin n_err++; $display("FAIL first_inst got %h want 00100513", bus.inst_out); end
        bus.stall_in = 1'b1;
      end
    end
  endtask

  task automatic test_stall;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      n_vec++; if (bus.instValid_out !== 1'b1 || bus.pc_out !== 32'h0 || bus.inst_out !== 32'h00100513 || bus.memRE_out !== 1'b0) begin
        n_err++; $display("FAIL stall_hold got v=%b pc=%h inst=%h re=%b want v=1 pc=0 inst=00100513 re=0",
                          bus.instValid_out, bus.pc_out, bus.inst_out, bus.memRE_out); end
    end
    bus.stall_in = 1'b0;
    @(negedge clk_in);
    n_vec++; if (bus.instValid_out !== 1'b0 || bus.memRE_out !== 1'b1 || bus.memAddr_out !== 32'h4) begin
      n_err++; $display("FAIL stall_release got v=%b re=%b addr=%h want v=0 re=1 addr=4",
                        bus.instValid_out, bus.memRE_out, bus.memAddr_out); end
  endtask

  task automatic test_grant_loss;
    bit ok;
    jump_to(32'h8);
    @(negedge clk_in);
    @(negedge clk_in);
    n_vec++; if (bus.memAddr_out !== 32'hA) begin n_err++; $display("FAIL gnt_f2_addr got %h want a", bus.memAddr_out); end
    bus.memGnt_in = 1'b0;
    @(negedge clk_in);
    n_vec++; if (bus.memRE_out !== 1'b0) begin n_err++; $display("FAIL gnt_abort_re got %b want 0", bus.memRE_out); end
    bus.memGnt_in = 1'b1;
    @(negedge clk_in);
    n_vec++; if (bus.memRE_out !== 1'b1 || bus.memAddr_out !== 32'h8) begin
      n_err++; $display("FAIL gnt_restart got re=%b addr=%h want re=1 addr=8", bus.memRE_out, bus.memAddr_out); end
    wait_valid(20, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL gnt_timeout got no valid want valid within 20 cycles"); end
    n_vec++; if (bus.pc_out !== 32'h8 || bus.inst_out !== word_at(32'h8)) begin
      n_err++; $display("FAIL gnt_word got pc=%h inst=%h want pc=8 inst=%h", bus.pc_out, bus.inst_out, word_at(32'h8)); end
  endtask

  task automatic test_jump;
    bit ok;
    jump_to(32'h4);
    repeat (3) @(negedge clk_in);
    n_vec++; if (bus.memAddr_out !== 32'h7) begin n_err++; $display("FAIL jump_f3_addr got %h want 7", bus.memAddr_out); end
    bus.jumpE_in = 1'b1; bus.jumpAddr_in = 32'h103;
    @(negedge clk_in);
    bus.jumpE_in = 1'b0;
    n_vec++; if (bus.instValid_out !== 1'b0 || bus.memRE_out !== 1'b1 || bus.memAddr_out !== 32'h100) begin
      n_err++; $display("FAIL jump_redirect got v=%b re=%b addr=%h want v=0 re=1 addr=100",
                        bus.instValid_out, bus.memRE_out, bus.memAddr_out); end
    wait_valid(20, ok);
    n_vec++; if (!ok || bus.pc_out !== 32'h100 || bus.inst_out !== word_at(32'h100)) begin
      n_err++; $display("FAIL jump_word got v=%b pc=%h inst=%h want v=1 pc=100 inst=%h",
                        bus.instValid_out, bus.pc_out, bus.inst_out, word_at(32'h100)); end
    // Jump on the same edge as consumption: target wins over pc+4.
    jump_to(32'h200);
    n_vec++; if (bus.instValid_out !== 1'b0 || bus.memAddr_out !== 32'h200) begin
      n_err++; $display("FAIL jump_vs_consume got v=%b addr=%h want v=0 addr=200", bus.instValid_out, bus.memAddr_out); end
  endtask

  task automatic test_wrap;
    bit ok;
    jump_to(32'hFFFF_FFFC);
    wait_valid(20, ok);
    n_vec++; if (!ok || bus.pc_out !== 32'hFFFF_FFFC || bus.inst_out !== word_at(32'hFFFF_FFFC)) begin
      n_err++; $display("FAIL wrap_word got v=%b pc=%h inst=%h want v=1 pc=fffffffc inst=%h",
                        bus.instValid_out, bus.pc_out, bus.inst_out, word_at(32'hFFFF_FFFC)); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      n_vec++; if (bus.memRE_out !== 1'b1 || bus.memAddr_out !== 32'(k)) begin
        n_err++; $display("FAIL wrap_addr%0d got re=%b addr=%h want re=1 addr=%0d", k, bus.memRE_out, bus.memAddr_out, k); end
    end
    wait_valid(20, ok);
    n_vec++; if (!ok || bus.pc_out !== 32'h0 || bus.inst_out !== word_at(32'h0)) begin
      n_err++; $display("FAIL wrap_next got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                        bus.instValid_out, bus.pc_out, bus.inst_out, word_at(32'h0)); end
  endtask

`ifdef IF_ICACHE_EN
  task automatic test_cache_loop;
    bus.stall_in = 1'b1;
    jump_to(32'h0);
    n_vec++; if (bus.memRE_out !== 1'b0 || bus.instValid_out !== 1'b0) begin
      n_err++; $display("FAIL cache_f0 got re=%b v=%b want re=0 v=0", bus.memRE_out, bus.instValid_out); end
    @(negedge clk_in);
    n_vec++; if (bus.instValid_out !== 1'b1 || bus.memRE_out !== 1'b0 || bus.pc_out !== 32'h0 || bus.inst_out !== word_at(32'h0)) begin
      n_err++; $display("FAIL cache_hit got v=%b re=%b pc=%h inst=%h want v=1 re=0 pc=0 inst=%h",
                        bus.instValid_out, bus.memRE_out, bus.pc_out, bus.inst_out, word_at(32'h0)); end
    bus.stall_in = 1'b0;
  endtask
`endif

  task automatic test_random;
    logic [31:0] exp_pc, tgt;
    int idle;
    bit do_jump;
    jump_to(32'h40);
    exp_pc = 32'h40;
    idle = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.instValid_out) begin
        idle = 0;
        n_vec++; if (bus.pc_out !== exp_pc || bus.inst_out !== word_at(exp_pc)) begin
          n_err++; $display("FAIL rand_word cycle %0d got pc=%h inst=%h want pc=%h inst=%h",
                            c, bus.pc_out, bus.inst_out, exp_pc, word_at(exp_pc)); end
      end else begin
        idle++;
      end
      if (idle > 150) begin
        n_vec++; n_err++; idle = 0;
        $display("FAIL rand_liveness cycle %0d got no word for 150 cycles want a delivery", c);
      end
      if (bus.memRE_out) begin
        n_vec++; if (bus.instValid_out !== 1'b0 || (bus.memAddr_out - exp_pc) > 32'd3) begin
          n_err++; $display("FAIL rand_bus cycle %0d got v=%b addr=%h want v=0 addr in pc=%h..+3",
                            c, bus.instValid_out, bus.memAddr_out, exp_pc); end
      end
      do_jump = ($urandom_range(0, 39) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 1023));
      bus.memGnt_in   = ($urandom_range(0, 9) != 0);
      bus.stall_in    = ($urandom_range(0, 3) == 0);
      bus.jumpE_in    = do_jump;
      bus.jumpAddr_in = tgt;
      if (do_jump)                                 exp_pc = {tgt[31:2], 2'b00};
      else if (bus.instValid_out && !bus.stall_in) exp_pc = exp_pc + 32'd4;
      @(negedge clk_in);
    end
    bus.jumpE_in = 1'b0; bus.memGnt_in = 1'b1; bus.stall_in = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    jump_to(32'h80);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    n_vec++; if (bus.instValid_out !== 1'b0 || bus.memRE_out !== 1'b0 || bus.memAddr_out !== 32'h0 ||
                 bus.pc_out !== 32'h0 || bus.inst_out !== 32'h0) begin
      n_err++; $display("FAIL midreset_async got v=%b re=%b addr=%h pc=%h inst=%h want all 0",
                        bus.instValid_out, bus.memRE_out, bus.memAddr_out, bus.pc_out, bus.inst_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int i = 0; i < 5 && !bus.memRE_out; i++) @(negedge clk_in);
    n_vec++; if (bus.memRE_out !== 1'b1 || bus.memAddr_out !== 32'h0) begin
      n_err++; $display("FAIL midreset_restart got re=%b addr=%h want re=1 addr=0", bus.memRE_out, bus.memAddr_out); end
    wait_valid(20, ok);
    n_vec++; if (!ok || bus.pc_out !== 32'h0 || bus.inst_out !== word_at(32'h0)) begin
      n_err++; $display("FAIL midreset_word got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                        bus.instValid_out, bus.pc_out, bus.inst_out, word_at(32'h0)); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
    bus.memData_in = 8'h0;
    test_reset;
    test_first_fetch;
    test_stall;
    test_grant_loss;
    test_jump;
    test_wrap;
`ifdef IF_ICACHE_EN
    test_cache_loop;
`endif
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
